// File: rtl/wdata_chan_slv_pkg.sv
// Shared encodings for the slave write-data receiver.
// FSM states and B-channel response codes.
package wdata_chan_slv_pkg;

    localparam logic [1:0] WSLV_IDLE = 2'd0;
    localparam logic [1:0] WSLV_DATA = 2'd1;
    localparam logic [1:0] WSLV_MWR  = 2'd2;
    localparam logic [1:0] WSLV_RESP = 2'd3;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;

    localparam int BEATS = 4;

endpackage

// File: rtl/wdata_chan_slv_if.sv
// AXI AW/W/B channel bundle between write master and slave.
// The master modport drives valids and payloads; the slave drives readies and B.
interface wdata_chan_slv_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32
);
    logic              awvalid;
    logic              awready;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic              wvalid;
    logic              wready;
    logic [31:0]       wdata;
    logic              wlast;
    logic              bvalid;
    logic              bready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;

    modport master (
        output awvalid, awid, awaddr, wvalid, wdata, wlast, bready,
        input  awready, wready, bvalid, bid, bresp
    );

    modport slave (
        input  awvalid, awid, awaddr, wvalid, wdata, wlast, bready,
        output awready, wready, bvalid, bid, bresp
    );
endinterface

// File: rtl/wdata_chan_slv_beat_packer.sv
// Beat counter plus 128-bit line assembler.
// Beat 0 lands in [31:0], beat 3 in [127:96].
module wdata_beat_packer
    import wdata_chan_slv_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         beat_en,
    input  logic [31:0]  wdata,
    output logic [1:0]   beat_cnt,
    output logic [127:0] line
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= 2'd0;
            line     <= '0;
        end else if (clr) begin
            beat_cnt <= 2'd0;
        end else if (beat_en) begin
            line[32*beat_cnt +: 32] <= wdata;
            beat_cnt                <= beat_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/wdata_chan_slv.sv
// Slave write-data receiver: one AW, a 4-beat W burst, one line write, one B.
// Serves a single burst at a time.
module wdata_chan_slv
    import wdata_chan_slv_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    wdata_chan_slv_if.slave     axi,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [127:0]        mem_wdata,
    input  logic                mem_wait
);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic              err;
    logic              err_nxt;
    logic              aw_hs;
    logic              w_hs;
    logic [1:0]        beat_cnt;
    logic [127:0]      line;

    // Readies come from state only, never from inputs.
    assign axi.awready = (state == WSLV_IDLE);
    assign axi.wready  = (state == WSLV_DATA);
    assign mem_we      = (state == WSLV_MWR);
    assign axi.bvalid  = (state == WSLV_RESP);
    assign axi.bid     = id_q;
    assign axi.bresp   = (axi.bvalid && err) ? BRESP_SLVERR : BRESP_OKAY;

    assign aw_hs = axi.awvalid & axi.awready;
    assign w_hs  = axi.wvalid & axi.wready;

    assign mem_addr  = {addr_q[ADDR_W-1:4], 4'b0};
    assign mem_wdata = line;

    wdata_beat_packer u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (aw_hs),
        .beat_en  (w_hs),
        .wdata    (axi.wdata),
        .beat_cnt (beat_cnt),
        .line     (line)
    );

    always_comb begin
        state_nxt = state;
        err_nxt   = err;
        unique case (state)
            WSLV_IDLE: begin
                if (axi.awvalid) begin
                    state_nxt = WSLV_DATA;
                    err_nxt   = 1'b0;
                end
            end
            WSLV_DATA: begin
                if (axi.wvalid) begin
                    if (axi.wlast && beat_cnt == 2'd3) begin
                        state_nxt = WSLV_MWR;
                    end else if (axi.wlast || beat_cnt == 2'd3) begin
                        state_nxt = WSLV_RESP;
                        err_nxt   = 1'b1;
                    end
                end
            end
            WSLV_MWR: begin
                if (!mem_wait) state_nxt = WSLV_RESP;
            end
            WSLV_RESP: begin
                if (axi.bready) state_nxt = WSLV_IDLE;
            end
            default: state_nxt = WSLV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= WSLV_IDLE;
            err    <= 1'b0;
            id_q   <= '0;
            addr_q <= '0;
        end else begin
            state <= state_nxt;
            err   <= err_nxt;
            if (aw_hs) begin
                id_q   <= axi.awid;
                addr_q <= axi.awaddr;
            end
        end
    end

endmodule
